// File: rtl/output_conditioner_pkg.sv
//==============================================================================
// Module      : output_conditioner_pkg
// Description : Shared state encodings and width helper for the output
//               conditioner and its dwell timer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package output_conditioner_pkg;

    // Two-state controller: waiting for a request, or holding the level.
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    // Dwell counter width: clog2(T), never narrower than one bit.
    function automatic int cnt_width(input int t);
        int w;
        w = $clog2(t);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : output_conditioner_pkg

`default_nettype wire

// File: rtl/output_conditioner_dwell_timer.sv
//==============================================================================
// Module      : output_conditioner_dwell_timer
// Description : Load/decrement down-counter that measures the dwell window.
//               A load presets T-1; expire is high once the count reaches 0.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module output_conditioner_dwell_timer
    import output_conditioner_pkg::*;
#(
    parameter int T = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expire
);

    localparam int              c_CW   = cnt_width(T);
    localparam logic [c_CW-1:0] c_LOAD = c_CW'(T - 1);

    logic [c_CW-1:0] r_cnt;

    // Count register: load wins over decrement, and the count parks at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_LOAD;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule : output_conditioner_dwell_timer

`default_nettype wire

// File: rtl/output_conditioner.sv
//==============================================================================
// Module      : output_conditioner
// Description : Converts 1-clk rise/fall requests into a registered output
//               level with a guaranteed minimum dwell of T cycles between
//               transitions, one queued request, and edge pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module output_conditioner
    import output_conditioner_pkg::*;
#(
    parameter int   T    = 4,
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic rise_req,
    input  logic fall_req,
    output logic sig_out,
    output logic busy,
    output logic pending,
    output logic rising,
    output logic falling
);

    logic [0:0] r_state;
    logic       r_sig;
    logic       r_pend;
    logic       r_plvl;
    logic       r_rise;
    logic       r_fall;

    logic       w_req_valid;
    logic       w_req_lvl;
    logic       w_expire;
    logic       w_eff_valid;
    logic       w_eff_lvl;
    logic       w_xfer;

    // Simultaneous rise and fall cancel each other out.
    assign w_req_valid = rise_req ^ fall_req;
    assign w_req_lvl   = rise_req;

    output_conditioner_dwell_timer #(
        .T (T)
    ) u_dwell_timer (
        .clk      (clk),
        .rst      (reset),
        .i_load   (w_xfer),
        .i_dec    (r_state == c_ST_HOLD),
        .o_expire (w_expire)
    );

    // Pick the request that may act now: a live request in IDLE, or at the
    // expire cycle a live request first, then the queued one.
    always_comb begin
        w_eff_valid = 1'b0;
        w_eff_lvl   = 1'b0;
        if (r_state == c_ST_IDLE) begin
            w_eff_valid = w_req_valid;
            w_eff_lvl   = w_req_lvl;
        end else if (w_expire) begin
            if (w_req_valid) begin
                w_eff_valid = 1'b1;
                w_eff_lvl   = w_req_lvl;
            end else if (r_pend) begin
                w_eff_valid = 1'b1;
                w_eff_lvl   = r_plvl;
            end
        end
        w_xfer = w_eff_valid && (w_eff_lvl != r_sig);
    end

    // Controller: output level, queued request, state and edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_sig   <= INIT;
            r_pend  <= 1'b0;
            r_plvl  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_xfer) begin
                r_sig   <= w_eff_lvl;
                r_state <= c_ST_HOLD;
                r_pend  <= 1'b0;
                r_rise  <= w_eff_lvl;
                r_fall  <= ~w_eff_lvl;
            end else if (r_state == c_ST_HOLD) begin
                if (w_expire) begin
                    // Nothing left that would change the level.
                    r_state <= c_ST_IDLE;
                    r_pend  <= 1'b0;
                end else if (w_req_valid) begin
                    // Last request wins; asking for the current level
                    // cancels a queued opposite request.
                    if (w_req_lvl != r_sig) begin
                        r_pend <= 1'b1;
                        r_plvl <= w_req_lvl;
                    end else begin
                        r_pend <= 1'b0;
                    end
                end
            end
        end
    end

    assign sig_out = r_sig;
    assign busy    = (r_state == c_ST_HOLD);
    assign pending = r_pend;
    assign rising  = r_rise;
    assign falling = r_fall;

endmodule : output_conditioner

`default_nettype wire

// File: tb/tb_output_conditioner.sv
//==============================================================================
// Module      : tb_output_conditioner
// Description : Self-checking bench: directed scenarios plus random requests,
//               compared every cycle against a cycle-counting reference model.
//               Two instances: T=4/INIT=0 and T=1/INIT=1.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_output_conditioner;

    localparam int c_BIG = 1000;

    typedef struct {
        logic out;
        int   since;   // cycles since the level last changed (0 = first cycle)
        logic pend;
        logic plvl;
        logic rp;
        logic fp;
    } mdl_t;

    logic clk;
    logic reset;
    logic rise_req;
    logic fall_req;
    logic sig_out,   busy,   pending,   rising,   falling;
    logic sig_out_1, busy_1, pending_1, rising_1, falling_1;

    int   checks;
    int   errors;
    mdl_t m4;
    mdl_t m1;

    output_conditioner #(.T(4), .INIT(1'b0)) u_dut4 (
        .clk      (clk),
        .reset    (reset),
        .rise_req (rise_req),
        .fall_req (fall_req),
        .sig_out  (sig_out),
        .busy     (busy),
        .pending  (pending),
        .rising   (rising),
        .falling  (falling)
    );

    output_conditioner #(.T(1), .INIT(1'b1)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .rise_req (rise_req),
        .fall_req (fall_req),
        .sig_out  (sig_out_1),
        .busy     (busy_1),
        .pending  (pending_1),
        .rising   (rising_1),
        .falling  (falling_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the level may change only once T cycles have elapsed since
    // the last change; the last such cycle (since == T-1) is the expire cycle.
    function automatic mdl_t mstep(mdl_t m, int tt, logic init,
                                   logic r, logic f, logic rs);
        mdl_t n;
        logic have;
        logic tgt;
        n    = m;
        n.rp = 1'b0;
        n.fp = 1'b0;
        have = 1'b0;
        tgt  = 1'b0;
        if (rs) begin
            n.out   = init;
            n.since = c_BIG;
            n.pend  = 1'b0;
            n.plvl  = 1'b0;
            return n;
        end
        if (m.since >= tt) begin
            if (r ^ f) begin
                have = 1'b1;
                tgt  = r;
            end
        end else if (m.since < tt - 1) begin
            if (r ^ f) begin
                if (r != m.out) begin
                    n.pend = 1'b1;
                    n.plvl = r;
                end else begin
                    n.pend = 1'b0;
                end
            end
        end else begin
            if (r ^ f) begin
                have = 1'b1;
                tgt  = r;
            end else if (m.pend) begin
                have = 1'b1;
                tgt  = m.plvl;
            end
            n.pend = 1'b0;
        end
        if (have && (tgt != m.out)) begin
            n.out   = tgt;
            n.since = 0;
            n.pend  = 1'b0;
            n.rp    = tgt;
            n.fp    = ~tgt;
        end else if (m.since < c_BIG) begin
            n.since = m.since + 1;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic rs);
        rise_req = r;
        fall_req = f;
        reset    = rs;
        @(posedge clk);
        m4 = mstep(m4, 4, 1'b0, r, f, rs);
        m1 = mstep(m1, 1, 1'b1, r, f, rs);
        #1;
        chk("t4_sig_out", sig_out, m4.out);
        chk("t4_busy",    busy,    (m4.since < 4));
        chk("t4_pending", pending, m4.pend);
        chk("t4_rising",  rising,  m4.rp);
        chk("t4_falling", falling, m4.fp);
        chk("t1_sig_out", sig_out_1, m1.out);
        chk("t1_busy",    busy_1,    (m1.since < 1));
        chk("t1_pending", pending_1, m1.pend);
        chk("t1_rising",  rising_1,  m1.rp);
        chk("t1_falling", falling_1, m1.fp);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        rise_req = 1'b0;
        fall_req = 1'b0;
        m4 = '{out: 1'b0, since: c_BIG, pend: 1'b0, plvl: 1'b0, rp: 1'b0, fp: 1'b0};
        m1 = '{out: 1'b1, since: c_BIG, pend: 1'b0, plvl: 1'b0, rp: 1'b0, fp: 1'b0};

        // Reset, then quiet for 10 cycles.
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        chk("quiet_sig_out", sig_out, 1'b0);
        chk("quiet_busy",    busy,    1'b0);

        // Rise from IDLE: visible next cycle, busy for 4 cycles.
        step(1'b1, 1'b0, 1'b0);
        chk("rise_sig_out", sig_out, 1'b1);
        chk("rise_pulse",   rising,  1'b1);
        chk("rise_busy",    busy,    1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("dwell_last_busy", busy,   1'b1);
        chk("dwell_pulse_off", rising, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("dwell_end_busy", busy,    1'b0);
        chk("dwell_end_sig",  sig_out, 1'b1);

        // Fall, then queue a rise and cancel it with a fall.
        step(1'b0, 1'b1, 1'b0);
        chk("fall_pulse", falling, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("queue_pending", pending, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("cancel_pending", pending, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        chk("cancel_sig", sig_out, 1'b0);
        chk("cancel_idle", busy,   1'b0);

        // Queued fall fires at the expire cycle, back-to-back HOLD.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("qfall_pending", pending, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("qfall_hold_sig", sig_out, 1'b1);
        chk("qfall_hold_pend", pending, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("qfall_sig",   sig_out, 1'b0);
        chk("qfall_pulse", falling, 1'b1);
        chk("qfall_busy",  busy,    1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("qfall_busy_end", busy, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("qfall_idle", busy, 1'b0);

        // Both requests together: nothing happens.
        step(1'b1, 1'b1, 1'b0);
        chk("both_sig",  sig_out, 1'b0);
        chk("both_pend", pending, 1'b0);
        chk("both_busy", busy,    1'b0);

        // Reset mid-dwell with a queued request.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("pre_rst_pend", pending, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("rst_sig",  sig_out, 1'b0);
        chk("rst_busy", busy,    1'b0);
        chk("rst_pend", pending, 1'b0);
        chk("rst_fall", falling, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Random requests with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 59) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_output_conditioner

`default_nettype wire
